// File: rtl/aes_inv_core_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys derived
// backwards from the round-10 key. Define AES_INV_CMP_IN_EN to accept complemented ciphertext.
module aes_inv_core_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] din,
  input  logic [127:0] kin,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);

  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] dout_q, dout_d;

  logic [127:0] din_enc;
  logic [31:0]  b0, b1, b2, b3;
  logic [127:0] rk_prev;
  logic [127:0] t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // a^254 by repeated squaring; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    end
    return r;
  endfunction

  // InvShiftRows folded into InvSubBytes: byte i of word j comes from word (j-i) mod 4
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        r[127-32*j-8*i -: 8] = inv_sbox(s[127-32*((j-i+4)%4)-8*i -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   c0, c1, c2, c3;
    for (int j = 0; j < 4; j++) begin
      c0 = s[127-32*j -: 8];
      c1 = s[119-32*j -: 8];
      c2 = s[111-32*j -: 8];
      c3 = s[103-32*j -: 8];
      r[127-32*j -: 8] = gf_mul(c0, 8'h0e) ^ gf_mul(c1, 8'h0b) ^ gf_mul(c2, 8'h0d) ^ gf_mul(c3, 8'h09);
      r[119-32*j -: 8] = gf_mul(c0, 8'h09) ^ gf_mul(c1, 8'h0e) ^ gf_mul(c2, 8'h0b) ^ gf_mul(c3, 8'h0d);
      r[111-32*j -: 8] = gf_mul(c0, 8'h0d) ^ gf_mul(c1, 8'h09) ^ gf_mul(c2, 8'h0e) ^ gf_mul(c3, 8'h0b);
      r[103-32*j -: 8] = gf_mul(c0, 8'h0b) ^ gf_mul(c1, 8'h0d) ^ gf_mul(c2, 8'h09) ^ gf_mul(c3, 8'h0e);
    end
    return r;
  endfunction

  // Round datapath plus load / round / completion sequencing
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;

`ifdef AES_INV_CMP_IN_EN
    din_enc = ~din;
`else
    din_enc = din;
`endif

    // Undo one key-schedule step: recover the previous round key from the current one
    b3      = rk_q[31:0]  ^ rk_q[63:32];
    b2      = rk_q[63:32] ^ rk_q[95:64];
    b1      = rk_q[95:64] ^ rk_q[127:96];
    b0      = rk_q[127:96] ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon_q, 24'h000000};
    rk_prev = {b0, b1, b2, b3};
    t       = inv_shift_sub(state_q) ^ rk_prev;

    if (!busy_q) begin
      if (start) begin
        state_d = din_enc ^ kin;
        rk_d    = kin;
        rnd_d   = 4'd10;
        rcon_d  = 8'h36;
        busy_d  = 1'b1;
      end else begin
        busy_d  = 1'b0;
      end
    end else if (rnd_q == 4'd0 || rnd_q > 4'd10) begin
      busy_d = 1'b0;
    end else begin
      rk_d   = rk_prev;
      rcon_d = (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);
      rnd_d  = rnd_q - 4'd1;
      if (rnd_q == 4'd1) begin
        dout_d = t;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        state_d = inv_mix_columns(t);
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 128'h0;
      rk_q    <= 128'h0;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h36;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule
